// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// Module  : noc_pkg
// Brief   : Flit id encodings, length width and requester state type.
// Rev     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package noc_pkg;

    localparam logic [2:0] FLIT_HEAD = 3'b001;
    localparam logic [2:0] FLIT_BODY = 3'b010;
    localparam logic [2:0] FLIT_TAIL = 3'b100;
    localparam int         LEN_W     = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2
    } req_state_t;

endpackage

`default_nettype wire

// File: rtl/flit_fifo.sv
// ---------------------------------------------------------------------------
// Module  : flit_fifo
// Brief   : Power-of-two circular flit buffer with combinational head output.
// Rev     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module flit_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int            c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_FULL);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage is not reset; entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/noc_port_requester.sv
// ---------------------------------------------------------------------------
// Module  : noc_port_requester
// Brief   : NoC input-port front end: flit FIFO plus arbiter request FSM.
//           Define FLIT_CHK_EN to enable flit-order checking and err pulses.
// Rev     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module noc_port_requester
    import noc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_flit,
    input  logic [2:0]        in_id,
    output logic              in_ready,
    input  logic              grant,
    output logic              req,
    output logic [2:0]        flit_id,
    output logic [LEN_W-1:0]  length,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_flit,
    output logic              err
);
    localparam int c_FLIT_W = DATA_W + 3;

    req_state_t          r_state;
    req_state_t          w_state_nxt;
    logic [LEN_W-1:0]    r_length;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_drop;
    logic                w_hold;
    logic                w_cap;
    logic                w_out_valid;
    logic [c_FLIT_W-1:0] w_head;
    logic [2:0]          w_head_id;
    logic                w_is_hdr;
    logic                w_is_tail;

    assign w_push = in_valid & ~w_full;
    assign w_pop  = w_out_valid | w_drop;

    flit_fifo #(
        .WIDTH (c_FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({in_id, in_flit}),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // Masking to 000 when empty lets id bits double as "head present" tests.
    assign w_head_id = w_empty ? 3'b000 : w_head[c_FLIT_W-1 -: 3];
    assign w_is_hdr  = |(w_head_id & FLIT_HEAD);
    assign w_is_tail = |(w_head_id & FLIT_TAIL);

    always_comb begin
        w_state_nxt = r_state;
        w_drop      = 1'b0;
        w_hold      = 1'b0;
        w_cap       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_is_hdr) begin
                    w_state_nxt = WAIT;
                    w_cap       = 1'b1;
                end
`ifdef FLIT_CHK_EN
                else if (!w_empty) begin
                    w_drop = 1'b1;
                end
`endif
            end
            WAIT: begin
                if (grant) begin
                    w_state_nxt = w_is_tail ? IDLE : XFER;
                end
            end
            XFER: begin
`ifdef FLIT_CHK_EN
                // Missing tail: hold the new header back and restart as a fresh packet.
                if (w_is_hdr) begin
                    w_hold      = 1'b1;
                    w_cap       = 1'b1;
                    w_state_nxt = WAIT;
                end else
`endif
                if (grant && w_is_tail) begin
                    w_state_nxt = IDLE;
                end else if (!grant) begin
                    w_state_nxt = WAIT;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_out_valid = grant & (r_state != IDLE) & ~w_empty & ~w_hold;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_length <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cap) r_length <= w_head[LEN_W-1:0];
        end
    end

`ifdef FLIT_CHK_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_drop | w_hold;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = ~w_full;
    assign req       = (r_state != IDLE);
    assign flit_id   = w_head_id;
    assign length    = r_length;
    assign out_valid = w_out_valid;
    assign out_flit  = w_head[DATA_W-1:0];

endmodule

`default_nettype wire
